// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: reset sequencing, lock qualification, retry/fault
// handling and dynamic phase-shift stepping, all in the CLKI domain.
module pll_lock_supervisor #(
    parameter int RST_HOLD_CYCLES = 20,
    parameter int LOCK_TIMEOUT    = 2000,
    parameter int STABLE_CYCLES   = 200,
    parameter int MAX_RETRIES     = 3,
    parameter int STEP_GAP        = 4
) (
    input  logic       CLKI,
    input  logic       RSTN,
    input  logic       LOCK,
    input  logic       CLR_FAULT,
    input  logic       PH_REQ,
    input  logic [1:0] PH_SEL,
    input  logic       PH_DIR,
    input  logic [3:0] PH_STEPS,
    output logic       PLL_RST,
    output logic       READY,
    output logic       FAULT,
    output logic [1:0] RETRY_CNT,
    output logic       PH_BUSY,
    output logic       PH_DONE,
    output logic [1:0] PHASESEL,
    output logic       PHASEDIR,
    output logic       PHASESTEP
);

    localparam int MAX_A   = (RST_HOLD_CYCLES > LOCK_TIMEOUT) ?
                             RST_HOLD_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_MAX = (MAX_A > STABLE_CYCLES) ?
                             MAX_A : STABLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int GAP_W   = (STEP_GAP > 1) ? $clog2(STEP_GAP) : 1;

    localparam logic [CNT_W-1:0] HOLD_END    = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_END = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_END  = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_SAT     = CNT_W'(CNT_MAX);
    localparam logic [GAP_W-1:0] GAP_END     = GAP_W'(STEP_GAP - 1);
    localparam logic [1:0]       RETRY_MAX   = 2'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_HOLD,
        S_WAIT,
        S_STABLE,
        S_RUN,
        S_PHASE,
        S_FAULT
    } state_t;

    typedef enum logic [1:0] {
        P_SETUP,
        P_HIGH,
        P_LOW
    } step_t;

    state_t           state_q;
    step_t            step_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic [GAP_W-1:0] gap_q;
    logic [3:0]       rem_q;
    logic [1:0]       lock_sync_q;
    logic             lock_s;

    logic       pll_rst_q;
    logic       ready_q;
    logic       fault_q;
    logic [1:0] retry_q;
    logic       ph_busy_q;
    logic       ph_done_q;
    logic [1:0] phasesel_q;
    logic       phasedir_q;
    logic       phasestep_q;

    // LOCK comes straight from the PLL analog macro; two flops before use.
    always_ff @(posedge CLKI or negedge RSTN) begin
        if (!RSTN) begin
            lock_sync_q <= 2'b00;
        end else begin
            lock_sync_q <= {lock_sync_q[0], LOCK};
        end
    end

    assign lock_s  = lock_sync_q[1];
    assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);

    always_ff @(posedge CLKI or negedge RSTN) begin
        if (!RSTN) begin
            state_q     <= S_HOLD;
            step_q      <= P_SETUP;
            cnt_q       <= '0;
            gap_q       <= '0;
            rem_q       <= 4'd0;
            pll_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
            retry_q     <= 2'd0;
            ph_busy_q   <= 1'b0;
            ph_done_q   <= 1'b0;
            phasesel_q  <= 2'd0;
            phasedir_q  <= 1'b0;
            phasestep_q <= 1'b0;
        end else begin
            ph_done_q <= 1'b0;
            unique case (state_q)
                S_HOLD: begin
                    pll_rst_q <= 1'b1;
                    ready_q   <= 1'b0;
                    if (cnt_q == HOLD_END) begin
                        state_q   <= S_WAIT;
                        pll_rst_q <= 1'b0;
                        cnt_q     <= '0;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                S_WAIT: begin
                    // Lock is tested first so it wins on the timeout cycle.
                    if (lock_s) begin
                        state_q <= S_STABLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == TIMEOUT_END) begin
                        pll_rst_q <= 1'b1;
                        cnt_q     <= '0;
                        if (retry_q == RETRY_MAX) begin
                            state_q <= S_FAULT;
                            fault_q <= 1'b1;
                        end else begin
                            state_q <= S_HOLD;
                            retry_q <= retry_q + 2'd1;
                        end
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                S_STABLE: begin
                    if (!lock_s) begin
                        state_q <= S_WAIT;
                        cnt_q   <= '0;
                    end else if (cnt_q == STABLE_END) begin
                        state_q <= S_RUN;
                        ready_q <= 1'b1;
                        retry_q <= 2'd0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                S_RUN: begin
                    if (!lock_s) begin
                        state_q   <= S_HOLD;
                        cnt_q     <= '0;
                        pll_rst_q <= 1'b1;
                        ready_q   <= 1'b0;
                    end else if (PH_REQ) begin
                        state_q    <= S_PHASE;
                        step_q     <= P_SETUP;
                        gap_q      <= '0;
                        rem_q      <= PH_STEPS;
                        phasesel_q <= PH_SEL;
                        phasedir_q <= PH_DIR;
                        ph_busy_q  <= 1'b1;
                    end
                end
                S_PHASE: begin
                    if (!lock_s) begin
                        state_q     <= S_HOLD;
                        cnt_q       <= '0;
                        pll_rst_q   <= 1'b1;
                        ready_q     <= 1'b0;
                        ph_busy_q   <= 1'b0;
                        phasestep_q <= 1'b0;
                    end else if (rem_q == 4'd0) begin
                        // Only reached for a zero-step request.
                        state_q   <= S_RUN;
                        ph_busy_q <= 1'b0;
                        ph_done_q <= 1'b1;
                    end else if (gap_q != GAP_END) begin
                        gap_q <= gap_q + GAP_W'(1);
                    end else begin
                        gap_q <= '0;
                        unique case (step_q)
                            P_SETUP: begin
                                step_q      <= P_HIGH;
                                phasestep_q <= 1'b1;
                            end
                            P_HIGH: begin
                                step_q      <= P_LOW;
                                phasestep_q <= 1'b0;
                            end
                            P_LOW: begin
                                if (rem_q == 4'd1) begin
                                    state_q   <= S_RUN;
                                    ph_busy_q <= 1'b0;
                                    ph_done_q <= 1'b1;
                                end else begin
                                    step_q <= P_SETUP;
                                end
                                rem_q <= rem_q - 4'd1;
                            end
                            default: begin
                                step_q <= P_SETUP;
                            end
                        endcase
                    end
                end
                S_FAULT: begin
                    pll_rst_q <= 1'b1;
                    ready_q   <= 1'b0;
                    fault_q   <= 1'b1;
                    if (CLR_FAULT) begin
                        state_q <= S_HOLD;
                        cnt_q   <= '0;
                        fault_q <= 1'b0;
                        retry_q <= 2'd0;
                    end
                end
                default: begin
                    state_q <= S_HOLD;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign PLL_RST   = pll_rst_q;
    assign READY     = ready_q;
    assign FAULT     = fault_q;
    assign RETRY_CNT = retry_q;
    assign PH_BUSY   = ph_busy_q;
    assign PH_DONE   = ph_done_q;
    assign PHASESEL  = phasesel_q;
    assign PHASEDIR  = phasedir_q;
    assign PHASESTEP = phasestep_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor: lock sequencing, retries,
// fault recovery and phase-step sequencing against hand-derived timing.
module tb_pll_lock_supervisor;

    logic       CLKI;
    logic       RSTN;
    logic       LOCK;
    logic       CLR_FAULT;
    logic       PH_REQ;
    logic [1:0] PH_SEL;
    logic       PH_DIR;
    logic [3:0] PH_STEPS;
    logic       PLL_RST;
    logic       READY;
    logic       FAULT;
    logic [1:0] RETRY_CNT;
    logic       PH_BUSY;
    logic       PH_DONE;
    logic [1:0] PHASESEL;
    logic       PHASEDIR;
    logic       PHASESTEP;

    int n_pass = 0;
    int n_chk  = 0;

    pll_lock_supervisor dut (
        .CLKI(CLKI), .RSTN(RSTN), .LOCK(LOCK), .CLR_FAULT(CLR_FAULT),
        .PH_REQ(PH_REQ), .PH_SEL(PH_SEL), .PH_DIR(PH_DIR),
        .PH_STEPS(PH_STEPS), .PLL_RST(PLL_RST), .READY(READY),
        .FAULT(FAULT), .RETRY_CNT(RETRY_CNT), .PH_BUSY(PH_BUSY),
        .PH_DONE(PH_DONE), .PHASESEL(PHASESEL), .PHASEDIR(PHASEDIR),
        .PHASESTEP(PHASESTEP)
    );

    initial begin
        CLKI = 1'b0;
        forever #5 CLKI = ~CLKI;
    end

    task automatic tick();
        @(posedge CLKI);
        #1;
    endtask

    // After this returns, the next posedge is cycle 1.
    task automatic do_reset();
        RSTN = 1'b0; LOCK = 1'b0; CLR_FAULT = 1'b0; PH_REQ = 1'b0;
        PH_SEL = 2'd0; PH_DIR = 1'b0; PH_STEPS = 4'd0;
        repeat (3) tick();
        @(negedge CLKI);
        RSTN = 1'b1;
    endtask

    task automatic test_reset();
        logic [10:0] v;
        RSTN = 1'b0; LOCK = 1'b1; CLR_FAULT = 1'b0; PH_REQ = 1'b1;
        PH_SEL = 2'd3; PH_DIR = 1'b1; PH_STEPS = 4'd5;
        repeat (4) tick();
        v = {PLL_RST, READY, FAULT, RETRY_CNT, PH_BUSY, PH_DONE,
             PHASESEL, PHASEDIR, PHASESTEP};
        n_chk++;
        if (v !== 11'b100_00_00_00_00)
            $display("FAIL reset_outputs: got %b want 10000000000", v);
        else n_pass++;
    endtask

    task automatic test_nominal();
        int  t_rst;
        int  t_rdy;
        bit  rst_back;
        t_rst = -1; t_rdy = -1; rst_back = 0;
        do_reset();
        for (int n = 1; n <= 300; n++) begin
            tick();
            if (n == 49) LOCK = 1'b1;
            if (t_rst >= 0 && PLL_RST !== 1'b0) rst_back = 1;
            if (t_rst < 0 && PLL_RST === 1'b0) t_rst = n;
            if (t_rdy < 0 && READY === 1'b1) t_rdy = n;
        end
        n_chk++;
        if (t_rst != 20) $display("FAIL nom_rst_fall: got %0d want 20", t_rst);
        else n_pass++;
        n_chk++;
        if (t_rdy != 253) $display("FAIL nom_ready: got %0d want 253", t_rdy);
        else n_pass++;
        n_chk++;
        if (RETRY_CNT !== 2'd0)
            $display("FAIL nom_retry: got %0d want 0", RETRY_CNT);
        else n_pass++;
        n_chk++;
        if (rst_back) $display("FAIL nom_rst_stay: got 1 want 0");
        else n_pass++;
    endtask

    task automatic test_phase_steps();
        int  bad; int pulses; int dones; int t_done;
        int  held_bad; int rdy_bad;
        logic prev; logic busy35; logic busy36; logic exp_s;
        bad = 0; pulses = 0; dones = 0; t_done = -1;
        held_bad = 0; rdy_bad = 0; prev = 1'b0;
        busy35 = 1'b0; busy36 = 1'b1;
        PH_SEL = 2'd2; PH_DIR = 1'b1; PH_STEPS = 4'd3; PH_REQ = 1'b1;
        tick();
        PH_REQ = 1'b0; PH_SEL = 2'd0; PH_DIR = 1'b0; PH_STEPS = 4'd0;
        n_chk++;
        if (PH_BUSY !== 1'b1) $display("FAIL ph_busy_set: got %b want 1", PH_BUSY);
        else n_pass++;
        for (int k = 1; k <= 44; k++) begin
            tick();
            exp_s = (k % 12 >= 4) && (k % 12 < 8) && (k < 36);
            if (PHASESTEP !== exp_s) bad++;
            if (PHASESTEP === 1'b1 && prev === 1'b0) pulses++;
            prev = PHASESTEP;
            if (PH_DONE === 1'b1) begin dones++; t_done = k; end
            if (k < 36 && (PHASESEL !== 2'd2 || PHASEDIR !== 1'b1)) held_bad++;
            if (READY !== 1'b1) rdy_bad++;
            if (k == 35) busy35 = PH_BUSY;
            if (k == 36) busy36 = PH_BUSY;
        end
        n_chk++;
        if (bad != 0) $display("FAIL ph_step_wave: got %0d bad cycles want 0", bad);
        else n_pass++;
        n_chk++;
        if (pulses != 3) $display("FAIL ph_pulses: got %0d want 3", pulses);
        else n_pass++;
        n_chk++;
        if (dones != 1 || t_done != 36)
            $display("FAIL ph_done: got %0d at %0d want 1 at 36", dones, t_done);
        else n_pass++;
        n_chk++;
        if (busy35 !== 1'b1 || busy36 !== 1'b0)
            $display("FAIL ph_busy_end: got %b%b want 10", busy35, busy36);
        else n_pass++;
        n_chk++;
        if (held_bad != 0) $display("FAIL ph_sel_dir: got %0d bad want 0", held_bad);
        else n_pass++;
        n_chk++;
        if (rdy_bad != 0) $display("FAIL ph_ready: got %0d low want 0", rdy_bad);
        else n_pass++;
    endtask

    task automatic test_zero_steps();
        int steps;
        steps = 0;
        PH_SEL = 2'd1; PH_DIR = 1'b0; PH_STEPS = 4'd0; PH_REQ = 1'b1;
        tick();
        PH_REQ = 1'b0;
        if (PHASESTEP === 1'b1) steps++;
        n_chk++;
        if ({PH_BUSY, PH_DONE} !== 2'b10)
            $display("FAIL zero_accept: got %b%b want 10", PH_BUSY, PH_DONE);
        else n_pass++;
        tick();
        if (PHASESTEP === 1'b1) steps++;
        n_chk++;
        if ({PH_BUSY, PH_DONE} !== 2'b01)
            $display("FAIL zero_done: got %b%b want 01", PH_BUSY, PH_DONE);
        else n_pass++;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (PHASESTEP === 1'b1 || PH_DONE === 1'b1) steps++;
        end
        n_chk++;
        if (steps != 0) $display("FAIL zero_nostep: got %0d want 0", steps);
        else n_pass++;
    endtask

    task automatic test_lock_loss_phase();
        logic s16; logic s19; logic r19; logic p19; logic b19;
        int dones;
        s16 = 1'b0; s19 = 1'b1; r19 = 1'b1; p19 = 1'b0; b19 = 1'b1;
        dones = 0;
        PH_SEL = 2'd2; PH_DIR = 1'b1; PH_STEPS = 4'd3; PH_REQ = 1'b1;
        tick();
        PH_REQ = 1'b0;
        for (int k = 1; k <= 45; k++) begin
            tick();
            if (PH_DONE === 1'b1) dones++;
            if (k == 16) begin s16 = PHASESTEP; LOCK = 1'b0; end
            if (k == 19) begin
                s19 = PHASESTEP; r19 = READY; p19 = PLL_RST; b19 = PH_BUSY;
            end
        end
        n_chk++;
        if (s16 !== 1'b1) $display("FAIL loss_in_high: got %b want 1", s16);
        else n_pass++;
        n_chk++;
        if ({s19, r19, p19, b19} !== 4'b0010)
            $display("FAIL loss_abort: got step/rdy/rst/busy %b%b%b%b want 0010",
                     s19, r19, p19, b19);
        else n_pass++;
        n_chk++;
        if (dones != 0) $display("FAIL loss_no_done: got %0d want 0", dones);
        else n_pass++;
    endtask

    task automatic test_ignored_req();
        int hits;
        hits = 0;
        for (int i = 0; i < 40 && PLL_RST !== 1'b0; i++) tick();
        n_chk++;
        if (PLL_RST !== 1'b0) $display("FAIL ign_reach_wait: got %b want 0", PLL_RST);
        else n_pass++;
        repeat (3) tick();
        PH_SEL = 2'd1; PH_DIR = 1'b1; PH_STEPS = 4'd2; PH_REQ = 1'b1;
        tick();
        PH_REQ = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (PH_BUSY === 1'b1 || PHASESTEP === 1'b1 || PH_DONE === 1'b1) hits++;
            tick();
        end
        n_chk++;
        if (hits != 0) $display("FAIL ign_req: got %0d busy cycles want 0", hits);
        else n_pass++;
    endtask

    task automatic test_unstable();
        int t_rdy; int t_rst; bit rst_back;
        t_rdy = -1; t_rst = -1; rst_back = 0;
        do_reset();
        for (int n = 1; n <= 400; n++) begin
            tick();
            if (n == 49)  LOCK = 1'b1;
            if (n == 149) LOCK = 1'b0;
            if (n == 154) LOCK = 1'b1;
            if (t_rst >= 0 && PLL_RST !== 1'b0) rst_back = 1;
            if (t_rst < 0 && PLL_RST === 1'b0) t_rst = n;
            if (t_rdy < 0 && READY === 1'b1) t_rdy = n;
        end
        // final rise sampled at cycle 155; 155 + 203 = 358
        n_chk++;
        if (t_rdy != 358) $display("FAIL unst_ready: got %0d want 358", t_rdy);
        else n_pass++;
        n_chk++;
        if (rst_back) $display("FAIL unst_no_hold: got 1 want 0");
        else n_pass++;
    endtask

    task automatic test_timeout_fault();
        int falls[$]; int rises[$];
        int exp_f[4]; int exp_r[4];
        int t_fault; int t_fall; int t_rdy; int got;
        logic [1:0] r1; logic [1:0] r2; logic [1:0] r3;
        logic prev;
        exp_f = '{20, 2040, 4060, 6080};
        exp_r = '{2020, 4040, 6060, 8080};
        t_fault = -1; r1 = 2'd0; r2 = 2'd0; r3 = 2'd0;
        do_reset();
        prev = 1'b1;
        for (int n = 1; n <= 8100; n++) begin
            tick();
            if (prev === 1'b1 && PLL_RST === 1'b0) falls.push_back(n);
            if (prev === 1'b0 && PLL_RST === 1'b1) rises.push_back(n);
            prev = PLL_RST;
            if (t_fault < 0 && FAULT === 1'b1) t_fault = n;
            if (n == 2030) r1 = RETRY_CNT;
            if (n == 4050) r2 = RETRY_CNT;
            if (n == 6070) r3 = RETRY_CNT;
        end
        for (int i = 0; i < 4; i++) begin
            got = (i < falls.size()) ? falls[i] : -1;
            n_chk++;
            if (got != exp_f[i])
                $display("FAIL to_fall%0d: got %0d want %0d", i, got, exp_f[i]);
            else n_pass++;
            got = (i < rises.size()) ? rises[i] : -1;
            n_chk++;
            if (got != exp_r[i])
                $display("FAIL to_rise%0d: got %0d want %0d", i, got, exp_r[i]);
            else n_pass++;
        end
        n_chk++;
        if ({r1, r2, r3} !== 6'b01_10_11)
            $display("FAIL to_retry_steps: got %0d,%0d,%0d want 1,2,3", r1, r2, r3);
        else n_pass++;
        n_chk++;
        if (t_fault != 8080) $display("FAIL to_fault_time: got %0d want 8080", t_fault);
        else n_pass++;
        n_chk++;
        if ({FAULT, PLL_RST, READY, RETRY_CNT} !== 5'b110_11)
            $display("FAIL to_fault_state: got %b want 11011",
                     {FAULT, PLL_RST, READY, RETRY_CNT});
        else n_pass++;
        CLR_FAULT = 1'b1; LOCK = 1'b1;
        tick();
        CLR_FAULT = 1'b0;
        n_chk++;
        if ({FAULT, RETRY_CNT, PLL_RST} !== 4'b0_00_1)
            $display("FAIL clr_state: got %b want 0001", {FAULT, RETRY_CNT, PLL_RST});
        else n_pass++;
        t_fall = -1; t_rdy = -1;
        for (int m = 1; m <= 260; m++) begin
            tick();
            if (t_fall < 0 && PLL_RST === 1'b0) t_fall = m;
            if (t_rdy < 0 && READY === 1'b1) t_rdy = m;
        end
        // lock already synced: WAIT_LOCK at 20, STABLE at 21, RUN 201 later
        n_chk++;
        if (t_fall != 20) $display("FAIL clr_rst_fall: got %0d want 20", t_fall);
        else n_pass++;
        n_chk++;
        if (t_rdy != 222) $display("FAIL clr_ready: got %0d want 222", t_rdy);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_phase_steps();
        test_zero_steps();
        test_lock_loss_phase();
        test_ignored_req();
        test_unstable();
        test_timeout_fault();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
- Sequences the board's EHXPLLL clock PLL (20 MHz ref in; 200 MHz CLKOP and 100 MHz CLKOS out) from the reference-clock domain.
- Holds the PLL in reset, then waits for lock and qualifies lock stability, then releases READY for downstream reset synchronisers.
- Retries on lock timeout and latches FAULT after repeated failures.
- In RUN, serves dynamic phase-shift requests by driving PHASESEL/PHASEDIR/PHASESTEP with the required pulse spacing.

Parameters:
- RST_HOLD_CYCLES, 20, cycles PLL_RST held high per attempt (1 us at 20 MHz).
- LOCK_TIMEOUT, 2000, cycles allowed in WAIT_LOCK before a retry.
- STABLE_CYCLES, 200, consecutive synced-lock cycles required before READY.
- MAX_RETRIES, 3, retries allowed before FAULT.
- STEP_GAP, 4, cycles for PHASESTEP setup, high time and low time.

Ports:
- CLKI  in  1  20 MHz reference clock; all logic in this domain.
- RSTN  in  1  asynchronous active-low reset.
- LOCK  in  1  PLL lock, asynchronous; 2-FF synchronised internally to lock_s.
- CLR_FAULT  in  1  level; restarts sequencing from FAULT.
- PH_REQ  in  1  phase-shift request, sampled only in RUN.
- PH_SEL  in  2  output select latched on accepted request.
- PH_DIR  in  1  direction latched on accepted request.
- PH_STEPS  in  4  step count latched on accepted request.
- PLL_RST  out  1  PLL reset, active-high.
- READY  out  1  clocks valid; downstream reset release.
- FAULT  out  1  lock failed after MAX_RETRIES retries.
- RETRY_CNT  out  2  retries taken in the current attempt sequence.
- PH_BUSY  out  1  phase sequence in progress.
- PH_DONE  out  1  one-cycle pulse when a phase sequence completes.
- PHASESEL  out  2  to PLL.
- PHASEDIR  out  1  to PLL.
- PHASESTEP  out  1  to PLL.

Behaviour:
- Reset values:
  - PLL_RST=1.
  - READY, FAULT, PH_BUSY, PH_DONE, PHASESTEP, PHASEDIR = 0.
  - PHASESEL=0, RETRY_CNT=0.
  - State HOLD, counter 0.
- All outputs are registered. Reset mid-operation returns to HOLD on the next edge; a pending phase sequence is lost.
- HOLD: PLL_RST=1. After RST_HOLD_CYCLES cycles, go to WAIT_LOCK with PLL_RST=0 and counter cleared.
- WAIT_LOCK:
  - lock_s=1 goes to STABLE.
  - Counter reaching LOCK_TIMEOUT with lock_s=0 is a timeout:
    - If RETRY_CNT==MAX_RETRIES, go to FAULT.
    - Otherwise RETRY_CNT+1, go to HOLD.
  - If lock_s rises on the timeout cycle, lock wins.
- STABLE:
  - Counter counts consecutive lock_s=1 cycles.
  - lock_s=0 returns to WAIT_LOCK with counter cleared; the timeout window restarts.
  - Count reaching STABLE_CYCLES goes to RUN.
- READY timing: READY=1 from the first RUN cycle. READY rises exactly STABLE_CYCLES+3 cycles after LOCK rises, provided LOCK stays high.
- RUN:
  - RETRY_CNT cleared on entry.
  - lock_s=0 sets READY=0, PLL_RST=1 and goes to HOLD. Lock loss has priority over PH_REQ.
  - PH_REQ=1 latches PH_SEL/PH_DIR/PH_STEPS and sets PH_BUSY=1.
    - PH_STEPS=0: PH_DONE pulses the next cycle, PH_BUSY returns to 0, no PHASESTEP.
    - Otherwise go to PHASE.
- PHASE:
  - PHASESEL/PHASEDIR are driven from the latched values for the whole sequence.
  - Per step: STEP_GAP setup cycles, then PHASESTEP=1 for STEP_GAP cycles, then 0 for STEP_GAP cycles; decrement remaining.
  - Remaining reaching 0 returns to RUN with PH_DONE one-cycle pulse and PH_BUSY=0.
  - READY stays 1 throughout.
  - PH_REQ is ignored while PH_BUSY=1.
  - lock_s=0 aborts: PHASESTEP=0 immediately (next edge), PH_BUSY=0, no PH_DONE, READY=0, go to HOLD.
- FAULT:
  - PLL_RST=1, FAULT=1, READY=0, RETRY_CNT holds MAX_RETRIES.
  - CLR_FAULT=1 clears FAULT and RETRY_CNT and goes to HOLD.
- Counter width: $clog2 of max(RST_HOLD_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)+1. No wrap; the counter saturates at its terminal value.

Test Plan:
- Nominal lock:
  - Stimulus: RSTN rises at cycle 0; LOCK rises at cycle 50 and stays high.
  - Required: PLL_RST falls at cycle 20; READY rises at cycle 253; RETRY_CNT=0.
- Unstable lock:
  - Stimulus: LOCK high 100 cycles, low 5 cycles, then high.
  - Required: READY rises only STABLE_CYCLES+3 cycles after the final rise.
  - Required: no HOLD re-entry (PLL_RST stays 0).
- Timeout and fault:
  - Stimulus: LOCK held 0.
  - Required: PLL_RST pulses 4 times (20 cycles each, 2000 cycles apart); RETRY_CNT steps 1,2,3; then FAULT=1 with PLL_RST=1.
  - Then CLR_FAULT pulse with LOCK=1: FAULT=0 and RETRY_CNT=0, and READY follows the nominal timing.
- Phase steps:
  - Stimulus: in RUN, PH_REQ with PH_SEL=2, PH_DIR=1, PH_STEPS=3.
  - Required: PHASESEL=2 and PHASEDIR=1 held; exactly 3 PHASESTEP pulses, each 4 cycles high and 4 cycles low.
  - Required: PH_DONE pulses once; PH_BUSY=0 afterwards; READY stays 1.
- Lock loss during phase:
  - Stimulus: LOCK drops during the 2nd PHASESTEP high.
  - Required: PHASESTEP=0 within 3 cycles; READY=0; PLL_RST=1; no PH_DONE.
- Zero steps and ignored request:
  - Stimulus: PH_STEPS=0 request.
  - Required: PH_DONE one cycle later, no PHASESTEP.
  - Stimulus: PH_REQ during WAIT_LOCK.
  - Required: ignored (PH_BUSY stays 0).
